// File: rtl/dcache_flush_engine.sv
// Walks every data-cache line, writes valid+dirty lines back to memory and
// clears dirty (and optionally valid) bits, holding the CPU cache off via busy_o.
module dcache_flush_engine #(
    parameter int LINES  = 32,
    parameter int IDX_W  = 5,
    parameter int TAG_W  = 22,
    parameter int LINE_W = 256,
    parameter int OFS_W  = 5,
    parameter int ADDR_W = TAG_W + IDX_W + OFS_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                inv_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [IDX_W:0]      wb_count_o,
    output logic [IDX_W-1:0]    line_idx_o,
    input  logic [TAG_W+1:0]    tag_i,
    input  logic [LINE_W-1:0]   data_i,
    output logic                tag_we_o,
    output logic [TAG_W+1:0]    tag_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    input  logic                mem_ack_i
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WB,
        UPD,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic                 inv_mode;
    logic [IDX_W:0]       wb_count;

    logic                 line_valid;
    logic                 line_dirty;
    logic [TAG_W-1:0]     line_tag;
    logic                 last_line;

    assign line_valid = tag_i[TAG_W+1];
    assign line_dirty = tag_i[TAG_W];
    assign line_tag   = tag_i[TAG_W-1:0];
    assign last_line  = (idx == LAST_IDX);

    assign line_idx_o  = idx;
    assign wb_count_o  = wb_count;
    assign mem_write_o = mem_enable_o;

    // Tag writes must land on the line currently addressed, so they follow
    // the SRAM read word combinationally instead of lagging a cycle.
    always_comb begin
        tag_we_o = 1'b0;
        tag_o    = '0;
        case (state)
            SCAN: begin
                if (!(line_valid && line_dirty) && inv_mode && line_valid) begin
                    tag_we_o = 1'b1;
                    tag_o    = {1'b0, 1'b0, line_tag};
                end
            end
            UPD: begin
                tag_we_o = 1'b1;
                tag_o    = {line_valid & ~inv_mode, 1'b0, line_tag};
            end
            default: begin
                tag_we_o = 1'b0;
                tag_o    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            idx          <= '0;
            inv_mode     <= 1'b0;
            wb_count     <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            mem_enable_o <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        inv_mode <= inv_i;
                        idx      <= '0;
                        wb_count <= '0;
                        busy_o   <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (line_valid && line_dirty) begin
                        mem_addr_o   <= {line_tag, idx, {OFS_W{1'b0}}};
                        mem_data_o   <= data_i;
                        mem_enable_o <= 1'b1;
                        state        <= WB;
                    end else if (last_line) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end
                WB: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        state        <= UPD;
                    end
                end
                UPD: begin
                    wb_count <= wb_count + CNT_ONE;
                    if (last_line) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx   <= idx + IDX_ONE;
                        state <= SCAN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
